dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer between the core's execute stage and the word-organised data memory.
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake and converts them to word-address memory cycles.
- Performs lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores, because the memory writes whole words only.
- Rejects misaligned and illegal requests with an error response and never touches memory for them.

Parameters:
- ADDR_W, 11, byte-address width; word address is ADDR_W-2 bits (default 9).
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, lane 0 aligned (bits 7:0 or 15:0 used for SB/SH).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal funct3.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_addr  out  ADDR_W-2  word address = latched addr[ADDR_W-1:2].
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable, sampled by memory at rising clk.
- mem_wd  out  32  full word to write.
- mem_rd  in  32  combinational read data from memory.

Behaviour:
- Handshake and latching
  - Accept on the rising edge where req_valid && req_ready.
  - addr, we, funct3 and wdata are latched at accept; request inputs are ignored while busy.
  - No response backpressure; resp_valid lasts exactly one cycle and is not held.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR.
  - IDLE: req_ready=1. On accept, go to ERR if the request is illegal. Otherwise go to LOAD (loads), STORE (SW) or RMW_RD (SB/SH).
  - Legal loads: funct3 000/001/010/100/101. Legal stores: 000/001/010. Any other funct3 is illegal.
  - Misaligned (also illegal): halfword with addr[0]=1; word with addr[1:0]!=0.
  - LOAD: mem_read=1. At the edge, capture the extended lane into resp_rdata, pulse resp_valid, go to IDLE.
  - STORE: mem_write=1, mem_wd=wdata. At the edge, pulse resp_valid, go to IDLE.
  - RMW_RD: mem_read=1. At the edge, latch merge = mem_rd with the target lane replaced by wdata, go to RMW_WR.
  - RMW_WR: mem_write=1, mem_wd=merge. At the edge, pulse resp_valid, go to IDLE.
  - ERR: no memory enables. At the edge, pulse resp_valid with resp_err=1 and resp_rdata=0, go to IDLE.
- Lanes (little-endian)
  - Byte at bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Halfword at bits [16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency, counted from the accept edge to the start of the resp_valid cycle:
  - Loads, SW, errors: 1 cycle; response appears the cycle after the single memory/ERR cycle.
  - SB/SH: 2 cycles.
  - The IDLE cycle carrying resp_valid also has req_ready=1, so back-to-back accepts are allowed.
- Memory outputs
  - mem_read and mem_write are decoded from state and gated with !rst; a write is never issued in a cycle where rst=1.
  - mem_read and mem_write are never both high.
  - mem_addr and mem_wd may hold stale values when both enables are low.
- Reset (synchronous)
  - Next state is IDLE; resp_valid, resp_err and resp_rdata go to 0; merge and latches clear.
  - Asserted mid-operation, the request is aborted with no response. A partially completed RMW leaves memory unchanged, since the write cycle is suppressed.
- Wrap-around: word address is a plain truncation; the top byte address maps to the last word, with no wrap logic.

Test Plan:
- Reset with req_valid=1 held: req_ready=0-equivalent idle, no mem_write or resp while rst=1. After release, req_ready=1 and all outputs 0.
- SW addr=0x010, wdata=0xDEADBEEF, then LW addr=0x010: mem_write at word 4 the cycle after accept; LW resp_rdata=0xDEADBEEF, resp_err=0, one cycle after accept.
- With word 4=0xDEADBEEF: LB addr=0x013 returns 0xFFFFFFDE; LBU returns 0x000000DE; LH addr=0x012 returns 0xFFFFDEAD; LHU addr=0x010 returns 0x0000BEEF.
- SB addr=0x011, wdata=0x55 on word 4=0xDEADBEEF: one read cycle then one write cycle with mem_wd=0xDEAD55EF; resp 2 cycles after accept. Repeat SH addr=0x012, wdata=0x1234, expecting 0x123455EF.
- LW addr=0x012, SH addr=0x013, and load funct3=011: each gives resp_valid with resp_err=1, resp_rdata=0, and no mem_read/mem_write.
- Reset asserted during RMW_RD of an SB: no write occurs, no resp; the word reads back unchanged afterwards. Also drive back-to-back requests held on req_valid and check that one is accepted every 2 cycles (word ops) or every 3 cycles (sub-word stores).

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: byte-addressed LB..SW requests to a word memory.
// Sub-word stores use read-modify-write; bad requests get an error reply.
module dmem_lsu_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              bad_f3, misalign;
  logic [4:0]        sh_b, sh_h;
  logic [DATA_W-1:0] rd_b, rd_h, ld_ext;
  logic [DATA_W-1:0] lane_mask, lane_ins;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = addr_q[ADDR_W-1:2];
  assign mem_read   = !rst &&
    (state_q == S_LOAD || state_q == S_RMW_RD);
  assign mem_write  = !rst &&
    (state_q == S_STORE || state_q == S_RMW_WR);
  assign mem_wd     = (state_q == S_RMW_WR) ?
    merge_q : wdata_q;

  assign sh_b = {addr_q[1:0], 3'b000};
  assign sh_h = {addr_q[1], 4'b0000};
  assign rd_b = mem_rd >> sh_b;
  assign rd_h = mem_rd >> sh_h;

  always_comb begin
    bad_f3 = 1'b0;
    if (req_we)
      bad_f3 = (req_funct3 > 3'd2);
    else
      bad_f3 = (req_funct3 == 3'd3) ||
               (req_funct3 > 3'd5);
    misalign =
      (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    ld_ext = '0;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{rd_b[7]}}, rd_b[7:0]};
      3'b001:  ld_ext = {{16{rd_h[15]}}, rd_h[15:0]};
      3'b010:  ld_ext = mem_rd;
      3'b100:  ld_ext = {24'b0, rd_b[7:0]};
      3'b101:  ld_ext = {16'b0, rd_h[15:0]};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    if (f3_q[0]) begin
      lane_mask = 32'h0000_FFFF << sh_h;
      lane_ins  = {16'b0, wdata_q[15:0]} << sh_h;
    end else begin
      lane_mask = 32'h0000_00FF << sh_b;
      lane_ins  = {24'b0, wdata_q[7:0]} << sh_b;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          if (bad_f3 || misalign)
            state_d = S_ERR;
          else if (!req_we)
            state_d = S_LOAD;
          else if (req_funct3 == 3'b010)
            state_d = S_STORE;
          else
            state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_ext;
        state_d      = S_IDLE;
      end
      S_STORE: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        merge_d = (mem_rd & ~lane_mask) | lane_ins;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: word memory, request-level reference model,
// directed literal cases plus randomized traffic with random resets.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [8:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr];
  always @(posedge clk)
    if (mem_write) mem[mem_addr] <= mem_wd;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp,
               $time);
    end
  endtask

  function automatic logic is_bad(input logic we, input logic [2:0] f3,
                                  input logic [10:0] a);
    logic ok;
    int   nb;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb = 1 << f3[1:0];
    return !ok || ((int'(a) % nb) != 0);
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] f3);
    int nb;
    nb = 1 << f3[1:0];
    if (nb >= 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * nb)) - 32'd1;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w,
      input logic [2:0] f3, input logic [10:0] a);
    logic [31:0] m, v;
    int nb;
    nb = 1 << f3[1:0];
    m  = size_mask(f3);
    v  = (w >> (8 * (int'(a) % 4))) & m;
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old,
      input logic [2:0] f3, input logic [10:0] a, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    m  = size_mask(f3);
    sh = 8 * (int'(a) % 4);
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // Request-level model: one outstanding op, remaining edges to reply.
  int          rem = 0;
  logic        p_we = 0, p_sub = 0, p_err = 0;
  logic [31:0] p_rdata = 0, p_new = 0;
  logic [8:0]  p_waddr = 0;
  logic        m_rv = 0, m_err = 0;
  logic [31:0] m_rdata = 0;

  always @(negedge clk) begin
    logic exp_rd, exp_wr;
    exp_rd = !rst && rem > 0 && !p_err &&
             (p_we ? (p_sub && rem == 2) : rem == 1);
    exp_wr = !rst && rem == 1 && p_we && !p_err;
    chk("req_ready", 32'(req_ready), 32'(rem == 0 && !rst));
    chk("resp_valid", 32'(resp_valid), 32'(m_rv));
    chk("resp_err", 32'(resp_err), 32'(m_err));
    if (m_rv) chk("resp_rdata", resp_rdata, m_rdata);
    chk("mem_read", 32'(mem_read), 32'(exp_rd));
    chk("mem_write", 32'(mem_write), 32'(exp_wr));
    if (exp_rd || exp_wr) chk("mem_addr", 32'(mem_addr), 32'(p_waddr));
    if (exp_wr) chk("mem_wd", mem_wd, p_new);

    m_rv = 0; m_err = 0; m_rdata = 0;
    if (rst) begin
      rem = 0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        m_rv = 1; m_err = p_err; m_rdata = p_rdata;
        if (p_we && !p_err) ref_mem[p_waddr] = p_new;
      end
    end else if (req_valid) begin
      p_we    = req_we;
      p_err   = is_bad(req_we, req_funct3, req_addr);
      p_waddr = 9'(req_addr / 4);
      p_sub   = req_we && req_funct3 != 3'd2;
      p_rdata = 0;
      p_new   = 0;
      rem     = 1;
      if (!p_err && !req_we)
        p_rdata = load_val(ref_mem[p_waddr], req_funct3, req_addr);
      else if (!p_err) begin
        p_new = store_val(ref_mem[p_waddr], req_funct3, req_addr,
                          req_wdata);
        if (p_sub) rem = 2;
      end
    end
  end

  task automatic xfer(input logic we, input logic [2:0] f3,
      input logic [10:0] a, input logic [31:0] wd,
      output logic [31:0] rd, output logic err, output int lat,
      output int nrd, output int nwr, output logic [31:0] lastwd);
    bit got;
    rd = 0; err = 0; lat = 0; nrd = 0; nwr = 0; lastwd = 0; got = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    req_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; lastwd = mem_wd; end
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; got = 1;
        break;
      end
      lat++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL xfer_timeout got=none expected=resp t=%0t", $time);
    end
  endtask

  task automatic burst(input logic we, input logic [2:0] f3,
      input logic [10:0] a, input logic [31:0] wd, output int n);
    n = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    @(posedge clk); #1;
    req_valid = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running expected=done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, lwd;
    logic        er;
    int          lat, nrd, nwr, n, nbad;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 0; ref_mem[i] = 0;
    end

    req_valid = 1; req_we = 1; req_funct3 = 3'd2;
    req_addr = 11'h010; req_wdata = 32'h1111_1111;
    repeat (4) @(negedge clk);
    chk("rst_no_write", 32'(mem_write), 32'd0);
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 0; rst = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_outs",
        32'({resp_valid, resp_err, mem_read, mem_write}), 32'd0);
    chk("post_rst_rdata", resp_rdata, 32'd0);

    xfer(1, 3'd2, 11'h010, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr, lwd);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_wd", lwd, 32'hDEAD_BEEF);
    chk("sw_err", 32'(er), 32'd0);
    xfer(0, 3'd2, 11'h010, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_lat", 32'(lat), 32'd1);
    xfer(0, 3'd0, 11'h013, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lb_data", rd, 32'hFFFF_FFDE);
    xfer(0, 3'd4, 11'h013, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lbu_data", rd, 32'h0000_00DE);
    xfer(0, 3'd1, 11'h012, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lh_data", rd, 32'hFFFF_DEAD);
    xfer(0, 3'd5, 11'h010, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lhu_data", rd, 32'h0000_BEEF);

    xfer(1, 3'd0, 11'h011, 32'h0000_0055, rd, er, lat, nrd, nwr, lwd);
    chk("sb_lat", 32'(lat), 32'd2);
    chk("sb_rw", 32'({nrd[3:0], nwr[3:0]}), 32'h11);
    chk("sb_wd", lwd, 32'hDEAD_55EF);
    xfer(1, 3'd1, 11'h012, 32'h0000_1234, rd, er, lat, nrd, nwr, lwd);
    chk("sh_lat", 32'(lat), 32'd2);
    chk("sh_wd", lwd, 32'h1234_55EF);
    xfer(0, 3'd2, 11'h010, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lw_after_rmw", rd, 32'h1234_55EF);

    xfer(0, 3'd2, 11'h012, 0, rd, er, lat, nrd, nwr, lwd);
    chk("lw_mis_err", 32'({er, rd != 0, nrd != 0, nwr != 0}), 32'h8);
    xfer(1, 3'd1, 11'h013, 32'hFFFF, rd, er, lat, nrd, nwr, lwd);
    chk("sh_mis_err", 32'({er, rd != 0, nrd != 0, nwr != 0}), 32'h8);
    xfer(0, 3'd3, 11'h010, 0, rd, er, lat, nrd, nwr, lwd);
    chk("f3_011_err", 32'({er, rd != 0, nrd != 0, nwr != 0}), 32'h8);
    chk("err_lat", 32'(lat), 32'd1);

    // Reset lands while the SB is in its read phase.
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_funct3 = 3'd0;
    req_addr = 11'h010; req_wdata = 32'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_write) n++;
    end
    chk("abort_quiet", 32'(n), 32'd0);
    xfer(0, 3'd2, 11'h010, 0, rd, er, lat, nrd, nwr, lwd);
    chk("abort_unchanged", rd, 32'h1234_55EF);

    burst(0, 3'd2, 11'h010, 0, n);
    chk("b2b_word", 32'(n), 32'd5);
    burst(1, 3'd0, 11'h011, 32'h55, n);
    chk("b2b_subword", 32'(n), 32'd3);

    xfer(1, 3'd2, 11'h7FF, 32'h0, rd, er, lat, nrd, nwr, lwd);
    chk("top_sw_mis", 32'(er), 32'd1);
    xfer(1, 3'd0, 11'h7FF, 32'h0000_00C3, rd, er, lat, nrd, nwr, lwd);
    xfer(0, 3'd2, 11'h7FC, 0, rd, er, lat, nrd, nwr, lwd);
    chk("top_byte", rd, 32'hC300_0000);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 199) == 0);
      req_valid  = ($urandom_range(0, 9) < 7);
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_wdata  = $urandom;
      if ($urandom_range(0, 9) == 0)
        req_addr = 11'h7FC + 11'($urandom_range(0, 3));
      else
        req_addr = 11'($urandom_range(0, 63));
    end
    @(posedge clk); #1;
    rst = 0; req_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    nbad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_final", 32'(nbad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
